// File: rtl/wb_port_arbiter_pkg.sv
// Shared definitions for the writeback port arbiter: source indices and select type.
package wb_port_arbiter_pkg;

  localparam int N_SRC = 8;
  localparam int SEL_W = 3;

  typedef logic [SEL_W-1:0] src_idx_t;

  localparam src_idx_t SRC_ALU  = 3'd0;
  localparam src_idx_t SRC_SFT  = 3'd1;
  localparam src_idx_t SRC_HILO = 3'd2;
  localparam src_idx_t SRC_MUL  = 3'd3;
  localparam src_idx_t SRC_DIV  = 3'd4;
  localparam src_idx_t SRC_LD   = 3'd5;
  localparam src_idx_t SRC_CP0  = 3'd6;
  localparam src_idx_t SRC_LNK  = 3'd7;

  // True when two or more sources are requesting in the same cycle.
  function automatic logic multi_req(input logic [N_SRC-1:0] v);
    return $countones(v) > 1;
  endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Request/writeback bundle between the eight result sources, the arbiter and the regfile.
interface wb_port_arbiter_if
  import wb_port_arbiter_pkg::*;
#(
  parameter int DW    = 32,
  parameter int RW    = 5,
  parameter int CNT_W = 16
);

  logic                   flush;
  logic [N_SRC-1:0]       req_valid;
  logic [N_SRC*DW-1:0]    req_data;
  logic [N_SRC*RW-1:0]    req_rd;
  logic [N_SRC-1:0]       req_ready;
  logic                   wb_ready;
  logic                   wb_valid;
  logic [DW-1:0]          wb_data;
  logic [RW-1:0]          wb_rd;
  src_idx_t               wb_sel;
  logic [CNT_W-1:0]       conflict_cnt;

  // slave: the arbiter itself; master: the sources plus the regfile port.
  modport slave (
    input  flush, req_valid, req_data, req_rd, wb_ready,
    output req_ready, wb_valid, wb_data, wb_rd, wb_sel, conflict_cnt
  );

  modport master (
    output flush, req_valid, req_data, req_rd, wb_ready,
    input  req_ready, wb_valid, wb_data, wb_rd, wb_sel, conflict_cnt
  );

endinterface

// File: rtl/wb_port_arbiter_pick.sv
// rr_pick8: one-cycle pick among eight requesters; masked sources win by lowest index,
// otherwise round-robin starting at ptr.
module rr_pick8
  import wb_port_arbiter_pkg::*;
(
  input  logic [N_SRC-1:0] req,
  input  src_idx_t         ptr,
  input  logic [N_SRC-1:0] prio_mask,
  output logic [N_SRC-1:0] gnt,
  output src_idx_t         idx,
  output logic             any
);

  logic [N_SRC-1:0] hi;
  src_idx_t         cand;

  // NOTE: every output gets a default before any branch, so no path leaves a latch.
  always_comb begin
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    hi   = req & prio_mask;
    if (|hi) begin
      // Descending scan so the lowest set index is the last (winning) assignment.
      for (int i = N_SRC - 1; i >= 0; i--) begin
        if (hi[i]) idx = src_idx_t'(i);
      end
      any = 1'b1;
    end else begin
      // 3-bit addition wraps 7 -> 0 for free.
      for (int k = N_SRC - 1; k >= 0; k--) begin
        cand = ptr + src_idx_t'(k);
        if (req[cand]) idx = cand;
      end
      any = |req;
    end
    gnt      = '0;
    gnt[idx] = any;
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: picks one of eight result sources per cycle and registers
// the winner's data, destination and source index into the regfile output stage.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int               DW        = 32,
  parameter int               RW        = 5,
  parameter logic [N_SRC-1:0] PRIO_MASK = 8'h00,
  parameter int               CNT_W     = 16
)(
  input  logic                clk,
  input  logic                rst_n,
  wb_port_arbiter_if.slave    bus
);

  src_idx_t         ptr;
  logic [CNT_W-1:0] cnt;
  logic [N_SRC-1:0] gnt;
  src_idx_t         idx;
  logic             any;
  logic             adv;
  logic             grant;
  logic             prio_hit;

  rr_pick8 u_pick (
    .req       (bus.req_valid),
    .ptr       (ptr),
    .prio_mask (PRIO_MASK),
    .gnt       (gnt),
    .idx       (idx),
    .any       (any)
  );

  // The output stage can take a new result when it is empty or being consumed.
  assign adv           = ~bus.flush & (~bus.wb_valid | bus.wb_ready);
  assign grant         = adv & any & rst_n;
  assign prio_hit      = |(bus.req_valid & PRIO_MASK);
  assign bus.req_ready = grant ? gnt : '0;
  assign bus.conflict_cnt = cnt;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.wb_valid <= 1'b0;
      bus.wb_data  <= '0;
      bus.wb_rd    <= '0;
      bus.wb_sel   <= SRC_ALU;
    end else if (bus.flush) begin
      bus.wb_valid <= 1'b0;
    end else if (grant) begin
      bus.wb_valid <= 1'b1;
      bus.wb_data  <= bus.req_data[idx*DW +: DW];
      bus.wb_rd    <= bus.req_rd[idx*RW +: RW];
      bus.wb_sel   <= idx;
    end else if (bus.wb_ready) begin
      bus.wb_valid <= 1'b0;
    end
  end

  // Only round-robin grants move the pointer; priority wins leave the rotation alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (grant && !prio_hit) begin
      ptr <= idx + src_idx_t'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (grant && multi_req(bus.req_valid) && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench: two arbiters (no priority / source 5 priority) share one random
// request stream and are checked against a rule-level reference model.
module tb_wb_port_arbiter;

  localparam int DW   = 32;
  localparam int RW   = 5;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [RW-1:0] rd;
    logic [2:0]    sel;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0]      req_valid = '0;
  logic [8*DW-1:0] req_data = '0;
  logic [8*RW-1:0] req_rd = '0;
  logic            wb_ready = 1'b1;
  logic            flush = 1'b0;

  always #5 clk = ~clk;

  wb_port_arbiter_if #(.DW(DW), .RW(RW), .CNT_W(CW)) bus0 ();
  wb_port_arbiter_if #(.DW(DW), .RW(RW), .CNT_W(CW)) bus1 ();

  assign bus0.req_valid = req_valid;
  assign bus0.req_data  = req_data;
  assign bus0.req_rd    = req_rd;
  assign bus0.wb_ready  = wb_ready;
  assign bus0.flush     = flush;
  assign bus1.req_valid = req_valid;
  assign bus1.req_data  = req_data;
  assign bus1.req_rd    = req_rd;
  assign bus1.wb_ready  = wb_ready;
  assign bus1.flush     = flush;

  wb_port_arbiter #(.DW(DW), .RW(RW), .PRIO_MASK(8'h00), .CNT_W(CW)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0));
  wb_port_arbiter #(.DW(DW), .RW(RW), .PRIO_MASK(8'h20), .CNT_W(CW)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1));

  logic [7:0]    o_ready [2];
  logic          o_valid [2];
  logic [DW-1:0] o_data  [2];
  logic [RW-1:0] o_rd    [2];
  logic [2:0]    o_sel   [2];
  logic [CW-1:0] o_cnt   [2];

  assign o_ready[0] = bus0.req_ready;    assign o_ready[1] = bus1.req_ready;
  assign o_valid[0] = bus0.wb_valid;     assign o_valid[1] = bus1.wb_valid;
  assign o_data[0]  = bus0.wb_data;      assign o_data[1]  = bus1.wb_data;
  assign o_rd[0]    = bus0.wb_rd;        assign o_rd[1]    = bus1.wb_rd;
  assign o_sel[0]   = bus0.wb_sel;       assign o_sel[1]   = bus1.wb_sel;
  assign o_cnt[0]   = bus0.conflict_cnt; assign o_cnt[1]   = bus1.conflict_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: m_* is the registered value, n_* the value after the next edge.
  int         m_ptr [2] = '{0, 0};
  int         n_ptr [2] = '{0, 0};
  bit         m_valid [2] = '{0, 0};
  bit         n_valid [2] = '{0, 0};
  int         m_cnt [2] = '{0, 0};
  int         n_cnt [2] = '{0, 0};
  logic [7:0] exp_ready [2] = '{8'h00, 8'h00};
  res_t       q0 [$];
  res_t       q1 [$];
  res_t       cur [2] = '{'0, '0};
  bit         prev_ready [2] = '{0, 0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] mask_of(input int k);
    return (k == 0) ? 8'h00 : 8'h20;
  endfunction

  // Lowest masked requester if any, else the first requester at or after ptr, mod 8.
  function automatic int model_pick(input logic [7:0] v, input int ptr, input logic [7:0] mask);
    logic [7:0] hm;
    hm = v & mask;
    for (int i = 0; i < 8; i++) if (hm[i]) return i;
    for (int s = 0; s < 8; s++) if (v[(ptr + s) % 8]) return (ptr + s) % 8;
    return -1;
  endfunction

  task automatic eval();
    for (int k = 0; k < 2; k++) begin
      bit   adv;
      int   p;
      res_t r;
      adv = !flush && (!m_valid[k] || wb_ready);
      p   = model_pick(req_valid, m_ptr[k], mask_of(k));
      n_valid[k]   = m_valid[k];
      n_ptr[k]     = m_ptr[k];
      n_cnt[k]     = m_cnt[k];
      exp_ready[k] = 8'h00;
      if (flush) begin
        n_valid[k] = 1'b0;
      end else if (adv && p >= 0) begin
        exp_ready[k] = 8'(1 << p);
        n_valid[k]   = 1'b1;
        r.data = req_data[p*DW +: DW];
        r.rd   = req_rd[p*RW +: RW];
        r.sel  = 3'(p);
        if (k == 0) q0.push_back(r); else q1.push_back(r);
        if ((req_valid & mask_of(k)) == 8'h00) n_ptr[k] = (p + 1) % 8;
        if ($countones(req_valid) >= 2 && m_cnt[k] < CMAX) n_cnt[k] = m_cnt[k] + 1;
      end else if (wb_ready) begin
        n_valid[k] = 1'b0;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      m_ptr[k]   = n_ptr[k];
      m_valid[k] = n_valid[k];
      m_cnt[k]   = n_cnt[k];
    end
  end

  // Requesters keep their fields while valid; idle lanes get fresh random payloads.
  task automatic drive(input logic [7:0] v, input logic rdy, input logic fl);
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      if (!v[i]) begin
        req_data[i*DW +: DW] = $urandom;
        req_rd[i*RW +: RW]   = 5'($urandom);
      end
    end
    req_valid = v;
    wb_ready  = rdy;
    flush     = fl;
    eval();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n     = 1'b0;
    req_valid = 8'hFF;
    flush     = 1'b0;
    wb_ready  = 1'b1;
    for (int k = 0; k < 2; k++) begin
      m_ptr[k] = 0;  n_ptr[k] = 0;
      m_valid[k] = 0; n_valid[k] = 0;
      m_cnt[k] = 0;  n_cnt[k] = 0;
      exp_ready[k] = 8'h00;
      cur[k] = '0;
    end
    q0.delete();
    q1.delete();
    repeat (2) @(posedge clk);
    #1;
    req_valid = 8'h00;
    rst_n     = 1'b1;
    eval();
  endtask

  // Monitor: every falling edge compare handshake/state, and pop a new expected result
  // whenever the DUT accepted something on the previous cycle.
  initial forever begin
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("req_ready[%0d]", k), 32'(o_ready[k]), 32'(exp_ready[k]));
      check($sformatf("wb_valid[%0d]", k), 32'(o_valid[k]), 32'(m_valid[k]));
      check($sformatf("conflict_cnt[%0d]", k), 32'(o_cnt[k]), 32'(m_cnt[k]));
      if (rst_n && prev_ready[k]) begin
        if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_underflow[%0d]: result seen with no expected entry at %0t", k, $time);
        end else if (k == 0) begin
          cur[0] = q0.pop_front();
        end else begin
          cur[1] = q1.pop_front();
        end
      end
      check($sformatf("wb_data[%0d]", k), o_data[k], cur[k].data);
      check($sformatf("wb_rd[%0d]", k), 32'(o_rd[k]), 32'(cur[k].rd));
      check($sformatf("wb_sel[%0d]", k), 32'(o_sel[k]), 32'(cur[k].sel));
      prev_ready[k] = rst_n && (o_ready[k] != 8'h00);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    // Reset with every source requesting.
    do_reset();

    // Full round-robin sweep with the output always consumed.
    repeat (9) drive(8'hFF, 1'b1, 1'b0);

    // Wrap from pointer 7 to 0, source 7 carrying a known word.
    drive(8'h40, 1'b1, 1'b0);
    @(negedge clk);
    check("rr_conflict9", 32'(o_cnt[0]), 32'd9);
    req_data[7*DW +: DW] = 32'hDEADBEEF;
    drive(8'h81, 1'b1, 1'b0);
    drive(8'h01, 1'b1, 1'b0);
    @(negedge clk);
    check("wrap_data", o_data[0], 32'hDEADBEEF);
    check("wrap_sel", 32'(o_sel[0]), 32'd7);

    // Backpressure: output full and not consumed for three cycles.
    drive(8'h08, 1'b1, 1'b0);
    repeat (3) begin
      drive(8'h30, 1'b0, 1'b0);
      @(negedge clk);
      check("bp_ready", 32'(o_ready[0]), 32'd0);
    end
    drive(8'h30, 1'b1, 1'b0);

    // Priority source 5 against round-robin requesters.
    do_reset();
    repeat (3) drive(8'h23, 1'b1, 1'b0);
    repeat (2) drive(8'h03, 1'b1, 1'b0);

    // Flush while a result is pending.
    drive(8'h10, 1'b1, 1'b0);
    drive(8'h04, 1'b0, 1'b1);
    @(negedge clk);
    check("flush_ready", 32'(o_ready[0]), 32'd0);
    drive(8'h04, 1'b0, 1'b0);
    drive(8'h00, 1'b1, 1'b0);

    // Random traffic with a mid-run reset.
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) do_reset();
      drive(8'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0);
    end

    repeat (4) drive(8'h00, 1'b1, 1'b0);
    check("sb_empty0", 32'(q0.size()), 32'd0);
    check("sb_empty1", 32'(q1.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
